pll_seq_ctrl: RTL and testbench
===============================

# pll_seq_ctrl

Power-up and relock sequencer for the ring PLL. It drives `ldo_enable` and `pllen` in the required order and qualifies the asynchronous `lock` with a stability filter. It gates the PLL output clock on only after lock is qualified, and retries on lock timeout. It sits between the SPI/mapcore configuration path (its `r_finish` pulse triggers relock) and the ringpll control pins, overriding the corresponding mapped fields.

## Interface
- `LDO_WAIT`, 256: cycles `ldo_enable` is held high before `pllen` asserts.
- `OFF_WAIT`, 16: cycles `pllen` is held low on relock or shutdown.
- `LOCK_TIMEOUT`, 4096: maximum cycles in WAIT_LOCK per attempt.
- `LOCK_STABLE`, 32: consecutive synchronized-lock-high cycles required to qualify lock.
- `MAX_RETRY`, 3: failed attempts allowed before ERROR.
- `clk` in 1: reference clock (same as PLL `clkref`).
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: pulse; begin power-up from IDLE or ERROR.
- `stop` in 1: pulse; orderly shutdown.
- `cfg_update` in 1: pulse (mapcore `r_finish`); new ratio loaded, force relock.
- `lock_async` in 1: raw PLL `lock`, asynchronous.
- `ldo_enable` out 1: to PLL LDO.
- `pllen` out 1: to PLL.
- `clk_en` out 1: output clock gate enable.
- `busy` out 1: high in any state except IDLE, LOCKED and ERROR.
- `locked` out 1: qualified lock.
- `err` out 1: sticky failure flag.
- `retry_cnt` out `$clog2(MAX_RETRY+1)`: failed attempts in the current sequence.

## Operation
- Lock input is passed through a 2-flop synchronizer, giving `lock_s`. A stability counter increments while `lock_s`=1, clears when `lock_s`=0, and saturates at `LOCK_STABLE`.
- States and registered outputs (ldo/pllen/clk_en/locked/err):
  - IDLE 0/0/0/0/0.
  - LDO_UP 1/0/0/0/0.
  - WAIT_LOCK 1/1/0/0/0.
  - LOCKED 1/1/1/1/0.
  - PLL_OFF 1/0/0/0/0.
  - SHUTDOWN 1/0/0/0/0.
  - ERROR 0/0/0/0/1.
- Transitions:
  - IDLE: on `start`, go to LDO_UP and clear `retry_cnt`.
  - LDO_UP: after `LDO_WAIT` cycles, go to WAIT_LOCK.
  - WAIT_LOCK: when the stability count reaches `LOCK_STABLE`, go to LOCKED. Otherwise, after `LOCK_TIMEOUT` cycles, increment `retry_cnt`. If the new value equals `MAX_RETRY`, go to ERROR; else go to PLL_OFF.
  - PLL_OFF: after `OFF_WAIT` cycles, go to WAIT_LOCK.
  - LOCKED: if `lock_s`=0, go to PLL_OFF with `retry_cnt` cleared (loss of lock). On `cfg_update`, go to PLL_OFF with `retry_cnt` cleared.
  - SHUTDOWN: after `OFF_WAIT` cycles, go to IDLE.
  - ERROR: on `start`, go to LDO_UP and clear `retry_cnt`; on `stop`, go to IDLE.
- Priority in the same cycle: `stop` > `cfg_update` > lock/timeout events.
  - `stop` in LDO_UP, WAIT_LOCK, LOCKED or PLL_OFF goes to SHUTDOWN. `stop` in IDLE or SHUTDOWN is ignored.
  - `cfg_update` in WAIT_LOCK or PLL_OFF restarts at PLL_OFF with `OFF_WAIT` reloaded and `retry_cnt` cleared. `cfg_update` in IDLE, LDO_UP, SHUTDOWN or ERROR is ignored.
  - `start` outside IDLE and ERROR is ignored.
- Stability and state counters clear on every state entry.
- `pllen` never asserts unless `ldo_enable` has been high for at least `LDO_WAIT` cycles.
- `clk_en` never asserts unless `pllen`=1.

## Timing
- Reset: all outputs 0, state IDLE, all counters and synchronizer flops 0.
- Every output is a registered Moore output of the state register; no combinational input-to-output paths.
- Counted states occupy exactly their parameter in cycles: exit when `cnt == PARAM-1`. Width is `$clog2` of the largest parameter.
- Lock qualification latency: `lock_async` rising (held high) to `locked`/`clk_en` high is 2 (sync) + `LOCK_STABLE` + 1 cycles.
- Loss of lock: `lock_async` falling in LOCKED to `clk_en` low is 3 cycles (2 sync + 1).
- `cfg_update` or `stop` in LOCKED: `clk_en` low on the next edge.
- A lock glitch shorter than `LOCK_STABLE` in WAIT_LOCK restarts the stability count; the timeout counter is unaffected.
- Reset asserted mid-sequence: immediate return to IDLE and all outputs 0, asynchronously.

## Structure
- `pll_seq_pkg`: state enum `pll_seq_state_e` (IDLE, LDO_UP, WAIT_LOCK, LOCKED, PLL_OFF, SHUTDOWN, ERROR) and default timing constants.
- Sub-module `pll_lock_sync`: 2-flop synchronizer plus saturating stability counter, outputting `lock_s` and `lock_ok`.
- Top level: instantiated in `pllmap_top`. `ldo_enable`/`pllen` replace the mapped fields, and `clk_en` gates `clkpll`.

## Test plan
- Normal bring-up (`LDO_WAIT`=8, `LOCK_STABLE`=4): `start`; `lock_async` held high from 5 cycles after `pllen` rises → `pllen` rises exactly 8 cycles after `ldo_enable`; `locked` follows 7 cycles after `lock_async`.
- Timeout with retry (`LOCK_TIMEOUT`=20, `MAX_RETRY`=3): `start`, `lock_async` held 0 → three WAIT_LOCK windows of 20 cycles, separated by `OFF_WAIT` pllen-low gaps; then `err`=1, `ldo_enable`=0, `retry_cnt`=3.
- Glitch filter: in WAIT_LOCK, `lock_async` high for 3 cycles, low for 1, then held high → `locked` only after 4 consecutive synchronized-high cycles.
- Loss of lock in LOCKED: drop `lock_async` → `clk_en` low after 3 cycles, `pllen` low for `OFF_WAIT` cycles, relock completes, `retry_cnt`=0.
- Simultaneous `stop` and `cfg_update` in LOCKED → SHUTDOWN taken; `pllen` low next cycle, `ldo_enable` low after `OFF_WAIT` cycles, then IDLE.
- `rst_n` asserted in WAIT_LOCK → all outputs 0 without waiting for a clock edge; after release, `start` performs a full `LDO_WAIT` sequence.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the ring PLL sequencer.
//   pll_seq_state_e : sequencer state encoding
//   pll_seq_out_t   : bundle of the registered control outputs
//   *_DEF           : default cycle counts for the sequencer parameters
package pll_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LDO_UP    = 3'd1,
    WAIT_LOCK = 3'd2,
    LOCKED    = 3'd3,
    PLL_OFF   = 3'd4,
    SHUTDOWN  = 3'd5,
    ERROR     = 3'd6
  } pll_seq_state_e;

  typedef struct packed {
    logic ldo_enable;
    logic pllen;
    logic clk_en;
    logic busy;
    logic locked;
    logic err;
  } pll_seq_out_t;

  localparam int unsigned LDO_WAIT_DEF     = 256;
  localparam int unsigned OFF_WAIT_DEF     = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF = 4096;
  localparam int unsigned LOCK_STABLE_DEF  = 32;
  localparam int unsigned MAX_RETRY_DEF    = 3;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width able to hold 0..max_val-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Lock qualifier: 2-flop synchronizer on the raw PLL lock and a saturating
// stability counter of consecutive synchronized-high cycles.
//   clk, rst_n     : reference clock, async active-low reset
//   lock_async_i   : raw PLL lock (asynchronous)
//   clr_i          : clears the stability count (state entry)
//   lock_s_o       : synchronized lock
//   lock_ok_o      : stability count has reached LOCK_STABLE
module pll_lock_sync
  import pll_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE = LOCK_STABLE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock_async_i,
  input  logic clr_i,
  output logic lock_s_o,
  output logic lock_ok_o
);

  localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(LOCK_STABLE);

  logic              sync1_q;
  logic              sync2_q;
  logic [STAB_W-1:0] stab_q;
  logic [STAB_W-1:0] stab_d;
  logic              ok_q;

  // Metastability synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= lock_async_i;
      sync2_q <= sync1_q;
    end
  end

  // Any low cycle restarts the count; saturate once qualified.
  always_comb begin
    stab_d = stab_q;
    if (clr_i || !sync2_q) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + STAB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_q <= '0;
      ok_q   <= 1'b0;
    end else begin
      stab_q <= stab_d;
      ok_q   <= (stab_d == STAB_MAX);
    end
  end

  assign lock_s_o  = sync2_q;
  assign lock_ok_o = ok_q;

endmodule

// File: rtl/pll_seq_ctrl.sv
// Power-up / relock sequencer for the ring PLL. Orders ldo_enable and pllen,
// qualifies lock, gates the PLL output clock and retries on lock timeout.
//   clk, rst_n  : reference clock, async active-low reset
//   start       : pulse, power up from IDLE or ERROR
//   stop        : pulse, orderly shutdown
//   cfg_update  : pulse, new ratio loaded, force relock
//   lock_async  : raw PLL lock
//   ldo_enable, pllen, clk_en, locked, err, busy : registered controls/status
//   retry_cnt   : failed lock attempts in the current sequence
module pll_seq_ctrl
  import pll_seq_pkg::*;
#(
  parameter int unsigned LDO_WAIT     = LDO_WAIT_DEF,
  parameter int unsigned OFF_WAIT     = OFF_WAIT_DEF,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int unsigned LOCK_STABLE  = LOCK_STABLE_DEF,
  parameter int unsigned MAX_RETRY    = MAX_RETRY_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             cfg_update,
  input  logic                             lock_async,
  output logic                             ldo_enable,
  output logic                             pllen,
  output logic                             clk_en,
  output logic                             busy,
  output logic                             locked,
  output logic                             err,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt
);

  localparam int unsigned CNT_W   = cnt_width(max3(LDO_WAIT, OFF_WAIT, LOCK_TIMEOUT));
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   LDO_LAST   = CNT_W'(LDO_WAIT - 1);
  localparam logic [CNT_W-1:0]   OFF_LAST   = CNT_W'(OFF_WAIT - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);

  pll_seq_state_e     state_q;
  pll_seq_state_e     state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [RETRY_W-1:0] retry_q;
  logic [RETRY_W-1:0] retry_d;
  logic [RETRY_W-1:0] retry_inc;
  logic               restart_c;
  logic               entry_c;
  logic               lock_s;
  logic               lock_ok;
  pll_seq_out_t       out_q;
  pll_seq_out_t       out_d;

  // A cfg_update in PLL_OFF re-enters the same state and must reload timing.
  assign entry_c = (state_d != state_q) || restart_c;

  pll_lock_sync #(
    .LOCK_STABLE (LOCK_STABLE)
  ) u_lock_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .lock_async_i (lock_async),
    .clr_i        (entry_c),
    .lock_s_o     (lock_s),
    .lock_ok_o    (lock_ok)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; stop outranks cfg_update, which outranks lock/timeout events.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    restart_c = 1'b0;
    retry_inc = retry_q + RETRY_W'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LDO_UP;
          retry_d = '0;
        end
      end
      LDO_UP: begin
        if (stop) begin
          state_d = SHUTDOWN;
        end else if (cnt_q == LDO_LAST) begin
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (stop) begin
          state_d = SHUTDOWN;
        end else if (cfg_update) begin
          state_d = PLL_OFF;
          retry_d = '0;
        end else if (lock_ok) begin
          state_d = LOCKED;
        end else if (cnt_q == TMO_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIM) ? ERROR : PLL_OFF;
        end
      end
      LOCKED: begin
        if (stop) begin
          state_d = SHUTDOWN;
        end else if (cfg_update || !lock_s) begin
          state_d = PLL_OFF;
          retry_d = '0;
        end
      end
      PLL_OFF: begin
        if (stop) begin
          state_d = SHUTDOWN;
        end else if (cfg_update) begin
          restart_c = 1'b1;
          retry_d   = '0;
        end else if (cnt_q == OFF_LAST) begin
          state_d = WAIT_LOCK;
        end
      end
      SHUTDOWN: begin
        if (cnt_q == OFF_LAST) begin
          state_d = IDLE;
        end
      end
      ERROR: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = LDO_UP;
          retry_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore output decode of the next state, registered alongside it.
  always_comb begin
    out_d = '0;
    case (state_d)
      LDO_UP, PLL_OFF, SHUTDOWN: begin
        out_d.ldo_enable = 1'b1;
        out_d.busy       = 1'b1;
      end
      WAIT_LOCK: begin
        out_d.ldo_enable = 1'b1;
        out_d.pllen      = 1'b1;
        out_d.busy       = 1'b1;
      end
      LOCKED: begin
        out_d.ldo_enable = 1'b1;
        out_d.pllen      = 1'b1;
        out_d.clk_en     = 1'b1;
        out_d.locked     = 1'b1;
      end
      ERROR: begin
        out_d.err = 1'b1;
      end
      default: begin
        out_d = '0;
      end
    endcase
  end

  // State timer, retry count and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      retry_q <= '0;
      out_q   <= '0;
    end else begin
      cnt_q   <= entry_c ? '0 : cnt_q + CNT_W'(1);
      retry_q <= retry_d;
      out_q   <= out_d;
    end
  end

  assign ldo_enable = out_q.ldo_enable;
  assign pllen      = out_q.pllen;
  assign clk_en     = out_q.clk_en;
  assign busy       = out_q.busy;
  assign locked     = out_q.locked;
  assign err        = out_q.err;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed bench for pll_seq_ctrl with shortened timing parameters.
module tb_pll_seq_ctrl;

  localparam int unsigned T_LDO = 8;
  localparam int unsigned T_OFF = 4;
  localparam int unsigned T_TMO = 20;
  localparam int unsigned T_STB = 4;
  localparam int unsigned T_RET = 3;

  // {ldo_enable, pllen, clk_en, busy, locked, err} per state
  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_LDO  = 6'b100100;
  localparam logic [5:0] O_WAIT = 6'b110100;
  localparam logic [5:0] O_LOCK = 6'b111010;
  localparam logic [5:0] O_OFF  = 6'b100100;
  localparam logic [5:0] O_ERR  = 6'b000001;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       start      = 1'b0;
  logic       stop       = 1'b0;
  logic       cfg_update = 1'b0;
  logic       lock_async = 1'b0;
  logic       ldo_enable;
  logic       pllen;
  logic       clk_en;
  logic       busy;
  logic       locked;
  logic       err;
  logic [1:0] retry_cnt;

  int n_total = 0;
  int n_bad   = 0;

  pll_seq_ctrl #(
    .LDO_WAIT     (T_LDO),
    .OFF_WAIT     (T_OFF),
    .LOCK_TIMEOUT (T_TMO),
    .LOCK_STABLE  (T_STB),
    .MAX_RETRY    (T_RET)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .cfg_update (cfg_update),
    .lock_async (lock_async),
    .ldo_enable (ldo_enable),
    .pllen      (pllen),
    .clk_en     (clk_en),
    .busy       (busy),
    .locked     (locked),
    .err        (err),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {ldo_enable, pllen, clk_en, busy, locked, err};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p, input logic c);
    start = s; stop = p; cfg_update = c;
    tick(1);
    start = 1'b0; stop = 1'b0; cfg_update = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_outs", 32'(outs()), 32'(O_IDLE));
    check_eq("rst_retry", 32'(retry_cnt), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_eq("idle_hold", 32'(outs()), 32'(O_IDLE));
    pulse(1'b0, 1'b1, 1'b1);
    check_eq("idle_stop_cfg_ign", 32'(outs()), 32'(O_IDLE));

    // Normal bring-up
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("bu_ldo_up", 32'(outs()), 32'(O_LDO));
    tick(T_LDO - 1);
    check_eq("bu_pllen_early", 32'(outs()), 32'(O_LDO));
    tick(1);
    check_eq("bu_pllen_rise", 32'(outs()), 32'(O_WAIT));
    tick(5);
    lock_async = 1'b1;
    tick(T_STB + 2);
    check_eq("bu_lock_early", 32'(outs()), 32'(O_WAIT));
    tick(1);
    check_eq("bu_locked", 32'(outs()), 32'(O_LOCK));
    check_eq("bu_retry", 32'(retry_cnt), 0);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("locked_start_ign", 32'(outs()), 32'(O_LOCK));

    // Loss of lock
    lock_async = 1'b0;
    tick(2);
    check_eq("lol_hold", 32'(outs()), 32'(O_LOCK));
    tick(1);
    check_eq("lol_off", 32'(outs()), 32'(O_OFF));
    check_eq("lol_retry", 32'(retry_cnt), 0);
    tick(T_OFF - 1);
    check_eq("lol_off_hold", 32'(outs()), 32'(O_OFF));
    tick(1);
    check_eq("lol_rewait", 32'(outs()), 32'(O_WAIT));
    lock_async = 1'b1;
    tick(T_STB + 2);
    check_eq("lol_relock_early", 32'(outs()), 32'(O_WAIT));
    tick(1);
    check_eq("lol_relocked", 32'(outs()), 32'(O_LOCK));
    check_eq("lol_retry_end", 32'(retry_cnt), 0);

    // stop + cfg_update together in LOCKED: SHUTDOWN wins
    pulse(1'b0, 1'b1, 1'b1);
    check_eq("sc_pllen_low", 32'(outs()), 32'(O_OFF));
    lock_async = 1'b0;
    tick(T_OFF - 1);
    check_eq("sc_ldo_hold", 32'(outs()), 32'(O_OFF));
    tick(1);
    check_eq("sc_idle", 32'(outs()), 32'(O_IDLE));

    // Glitch filter
    pulse(1'b1, 1'b0, 1'b0);
    tick(T_LDO);
    check_eq("gl_wait", 32'(outs()), 32'(O_WAIT));
    lock_async = 1'b1;
    tick(3);
    lock_async = 1'b0;
    tick(1);
    lock_async = 1'b1;
    tick(3);
    check_eq("gl_no_early_lock", 32'(outs()), 32'(O_WAIT));
    tick(3);
    check_eq("gl_pre_lock", 32'(outs()), 32'(O_WAIT));
    tick(1);
    check_eq("gl_locked", 32'(outs()), 32'(O_LOCK));

    // cfg_update in LOCKED, then restart of PLL_OFF by a second cfg_update
    pulse(1'b0, 1'b0, 1'b1);
    check_eq("cfg_off", 32'(outs()), 32'(O_OFF));
    tick(T_OFF);
    check_eq("cfg_wait", 32'(outs()), 32'(O_WAIT));
    tick(T_STB);
    check_eq("cfg_stab_cleared", 32'(outs()), 32'(O_WAIT));
    tick(1);
    check_eq("cfg_locked", 32'(outs()), 32'(O_LOCK));
    pulse(1'b0, 1'b0, 1'b1);
    tick(2);
    pulse(1'b0, 1'b0, 1'b1);
    tick(T_OFF - 1);
    check_eq("off_restart_hold", 32'(outs()), 32'(O_OFF));
    tick(1);
    check_eq("off_restart_wait", 32'(outs()), 32'(O_WAIT));
    tick(T_STB);
    tick(1);
    check_eq("off_restart_lock", 32'(outs()), 32'(O_LOCK));
    pulse(1'b0, 1'b1, 1'b0);
    lock_async = 1'b0;
    tick(T_OFF);
    check_eq("stop_idle", 32'(outs()), 32'(O_IDLE));

    // Timeout with retries
    pulse(1'b1, 1'b0, 1'b0);
    tick(T_LDO);
    check_eq("to_wait", 32'(outs()), 32'(O_WAIT));
    for (int w = 1; w <= int'(T_RET); w++) begin
      tick(T_TMO - 1);
      check_eq("to_window_end", 32'(outs()), 32'(O_WAIT));
      check_eq("to_window_retry", 32'(retry_cnt), 32'(w - 1));
      tick(1);
      if (w < int'(T_RET)) begin
        check_eq("to_off", 32'(outs()), 32'(O_OFF));
        check_eq("to_retry", 32'(retry_cnt), 32'(w));
        tick(T_OFF - 1);
        check_eq("to_off_hold", 32'(outs()), 32'(O_OFF));
        tick(1);
        check_eq("to_rewait", 32'(outs()), 32'(O_WAIT));
      end else begin
        check_eq("to_error", 32'(outs()), 32'(O_ERR));
        check_eq("to_retry_max", 32'(retry_cnt), 32'(T_RET));
      end
    end
    pulse(1'b0, 1'b0, 1'b1);
    check_eq("err_cfg_ign", 32'(outs()), 32'(O_ERR));
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("err_restart", 32'(outs()), 32'(O_LDO));
    check_eq("err_restart_retry", 32'(retry_cnt), 0);

    // Async reset in WAIT_LOCK
    tick(T_LDO);
    check_eq("ar_wait", 32'(outs()), 32'(O_WAIT));
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_outs", 32'(outs()), 32'(O_IDLE));
    check_eq("ar_retry", 32'(retry_cnt), 0);
    #1 rst_n = 1'b1;
    tick(1);
    check_eq("ar_idle", 32'(outs()), 32'(O_IDLE));
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("ar_ldo_up", 32'(outs()), 32'(O_LDO));
    tick(T_LDO - 1);
    check_eq("ar_pllen_early", 32'(outs()), 32'(O_LDO));
    tick(1);
    check_eq("ar_pllen_rise", 32'(outs()), 32'(O_WAIT));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
